// File: rtl/grant_arbiter.sv
// grant_arbiter: 4-way fixed-priority / round-robin arbiter with bounded grant hold.
module grant_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       idle
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_nx;
    logic [1:0] id_nx, last, last_nx;
    logic [7:0] hold_cnt, hold_nx;
    logic [2:0] win, win_masked;
    // Returns {found, index}; fixed picks the highest bit, round-robin the first after l.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic m, input logic [1:0] l);
        logic [2:0] res;
        logic [1:0] i;
        res = '0;
        for (int k = 0; k < 4; k++)
            if (!m && r[k]) res = {1'b1, 2'(k)};
        for (int k = 4; k >= 1; k--) begin
            i = l + 2'(k);
            if (m && r[i]) res = {1'b1, i};
        end
        return res;
    endfunction
    assign win        = pick(req, mode, last);
    assign win_masked = pick(req & ~(4'b1 << gnt_id), mode, last);
    assign gnt_valid  = state == GRANT;
    assign idle       = state == IDLE;
    assign gnt        = gnt_valid ? 4'b1 << gnt_id : 4'b0;
    always_comb begin
        state_nx = state;
        id_nx    = gnt_id;
        last_nx  = last;
        hold_nx  = hold_cnt + 8'd1;
        if (state == IDLE || !en || !req[gnt_id]) begin
            if (en && win[2]) begin
                state_nx = GRANT;
                id_nx    = win[1:0];
                last_nx  = win[1:0];
            end else begin
                state_nx = IDLE;
                id_nx    = 2'd0;
            end
            hold_nx = 8'd0;
        end else if (hold_cnt == 8'(HOLD_MAX - 1)) begin
            id_nx   = win_masked[2] ? win_masked[1:0] : gnt_id;
            last_nx = id_nx;
            hold_nx = 8'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_id   <= 2'd0;
            last     <= 2'd3;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_nx;
            gnt_id   <= id_nx;
            last     <= last_nx;
            hold_cnt <= hold_nx;
        end
    end
endmodule

// File: tb/tb_grant_arbiter.sv
// tb_grant_arbiter: directed and random stimulus against an ownership-tracking model of the arbiter.
module tb_grant_arbiter;
    localparam int H = 8;
    logic clk = 0, rst = 0, en = 0, mode = 0;
    logic [3:0] req = '0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic gnt_valid, idle;
    int n_vec = 0, n_err = 0;
    int owner = -1, held = 0, recent = 3;

    grant_arbiter #(.HOLD_MAX(H)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .idle(idle)
    );

    always #5 clk = ~clk;

    function automatic int choose(input logic [3:0] r, input logic m, input int from_last);
        int idx;
        if (!m) begin
            for (int i = 3; i >= 0; i--) if (r[i]) return i;
            return -1;
        end
        for (int k = 1; k <= 4; k++) begin
            idx = (from_last + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model(input logic r, input logic e, input logic m, input logic [3:0] q);
        int w;
        if (r) begin
            owner = -1; held = 0; recent = 3;
        end else if (owner < 0 || !e || !q[owner]) begin
            w = e ? choose(q, m, recent) : -1;
            owner = w; held = 0;
            if (w >= 0) recent = w;
        end else if (held == H - 1) begin
            w = choose(q & ~(4'b1 << owner), m, recent);
            if (w < 0) w = owner;
            owner = w; held = 0; recent = w;
        end else held++;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic m, input logic [3:0] q);
        logic [3:0] eg;
        rst = r; en = e; mode = m; req = q;
        @(posedge clk);
        model(r, e, m, q);
        #1;
        eg = owner < 0 ? 4'b0 : 4'b1 << owner;
        check("model", {gnt, gnt_id, gnt_valid, idle},
              {eg, owner < 0 ? 2'd0 : 2'(owner), owner >= 0, owner < 0});
    endtask

    initial begin
        logic [3:0] q;
        step(1, 0, 0, 4'b0000);
        check("reset_gnt", {4'b0, gnt}, 8'h00);
        check("reset_idle", {6'b0, gnt_valid, idle}, 8'h01);
        step(0, 1, 0, 4'b0110);
        check("fixed_first", {2'b0, gnt, gnt_id}, {2'b0, 4'b0100, 2'd2});
        step(0, 1, 0, 4'b0010);
        check("fixed_drop_nogap", {2'b0, gnt, gnt_id}, {2'b0, 4'b0010, 2'd1});
        step(1, 0, 1, 4'b0000);
        for (int k = 0; k < 40; k++) begin
            step(0, 1, 1, 4'b1111);
            check("rr_rotate", {4'b0, gnt}, {4'b0, 4'b1 << ((k / 8) % 4)});
        end
        step(1, 0, 0, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 0, 4'b0010);
            check("timeout_regrant", {4'b0, gnt}, 8'h02);
        end
        step(1, 0, 0, 4'b0000);
        step(0, 1, 0, 4'b0001);
        check("nopreempt_start", {4'b0, gnt}, 8'h01);
        for (int k = 0; k < 7; k++) begin
            step(0, 1, 0, 4'b1001);
            check("nopreempt_hold", {4'b0, gnt}, 8'h01);
        end
        step(0, 1, 0, 4'b1001);
        check("nopreempt_switch", {4'b0, gnt}, 8'h08);
        step(0, 0, 0, 4'b1001);
        check("en_low_release", {3'b0, gnt, idle}, 8'h01);
        step(0, 1, 1, 4'b1111);
        step(0, 1, 1, 4'b1111);
        step(1, 1, 1, 4'b1111);
        check("rst_midgrant", {1'b0, gnt, gnt_id, idle}, 8'h01);
        step(0, 1, 1, 4'b0110);
        check("rr_after_reset", {2'b0, gnt, gnt_id}, {2'b0, 4'b0010, 2'd1});
        q = 4'b0000;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) < 3) q = 4'($urandom);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0,
                 $urandom_range(0, 49) == 0 ? ~mode : mode, q);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
